change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
- Downstream stage of the vending controller.
- Accepts a change amount in cents with a one-cycle start strobe, then dispenses it greedily as quarters, dimes and nickels.
- Each coin is one release pulse on relq/reld/reln.
- Tracks an on-board coin inventory per denomination and reports done/short status back to the controller.

Parameters:
- AMT_W, 8, width of amount and remaining-change datapath in cents
- INV_W, 6, width of each coin inventory counter
- INIT_Q, 8, quarter count loaded at reset/refill
- INIT_D, 8, dime count loaded at reset/refill
- INIT_N, 8, nickel count loaded at reset/refill
- GAP, 1, idle cycles inserted after every release pulse (0 legal)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle request to dispense amount
- amount  in  AMT_W  change owed in cents, sampled with start
- refill  in  1  reload inventory to INIT_* values
- busy  out  1  dispensing in progress
- done  out  1  one-cycle completion pulse
- short  out  1  last job ended with ≥5 cents unpaid; held until next start
- remain  out  AMT_W  cents still owed (residue after done)
- relq  out  1  release one quarter (one-cycle pulse)
- reld  out  1  release one dime
- reln  out  1  release one nickel
- q_cnt, d_cnt, n_cnt  out  INV_W each  current inventory
- low_coin  out  1  any inventory counter equals 0
- total_out  out  16  cumulative cents dispensed (see Optional Feature)

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high, on ports clk/reset.
- Reset values:
  - state IDLE
  - busy, done, short, relq, reld, reln = 0
  - remain = 0
  - q_cnt/d_cnt/n_cnt = INIT_Q/INIT_D/INIT_N
  - low_coin derived from counts
  - total_out = 0
- Registered outputs: all outputs are registered except low_coin, which is combinational from the counts.
- States: IDLE, DISP, GAP, DONE.
- IDLE:
  - On an edge with start=1: remain<=amount, short<=0, busy<=1, go DISP.
  - start while busy or in DONE is ignored; no queuing.
- DISP, one decision per edge, priority in this order:
  - remain≥25 and q_cnt>0: relq<=1, remain-=25, q_cnt-=1.
  - else remain≥10 and d_cnt>0: reld<=1, remain-=10, d_cnt-=1.
  - else remain≥5 and n_cnt>0: reln<=1, remain-=5, n_cnt-=1.
  - After issuing a pulse: go GAP if GAP>0, else stay in DISP.
  - If no coin fits: busy<=0, done<=1, short<=(remain≥5), go DONE.
- Pulse timing: at most one rel* high in any cycle. Each pulse lasts exactly one cycle.
- GAP: count GAP cycles with all rel* low, then return to DISP.
- DONE: one cycle (done high), then IDLE. done and busy are never high together.
- Latency:
  - First release pulse is visible in the 2nd cycle after the start edge.
  - amount=0: done visible in the 2nd cycle, with no pulses.
- Residue: 1–4 cents is left in remain and does not set short.
- Greedy fallback: a missing denomination falls back to smaller coins. Example: q_cnt=0, 50 cents is paid as 5 dimes.
- Arithmetic: remain never underflows, because every subtraction is guarded by its compare. Counters never go below 0.
- Refill:
  - Honoured only in IDLE; ignored while busy/GAP/DONE.
  - refill and start on the same edge: counts reload and the job starts on that edge. The job uses the reloaded counts.
- Reset mid-operation: aborts immediately with no further pulses. A pulse in flight is cleared asynchronously. Inventory restores to INIT_*.

Optional Feature:
- Macro: CHANGE_STATS_EN.
- Defined: total_out accumulates the value of every coin released (25/10/5). It wraps modulo 2^16 and is cleared only by reset.
- Undefined: total_out is tied to 0 and no accumulator logic is built.
- All other behaviour is identical either way.

Test Plan:
- Defaults, start with amount=75 → relq pulses 3 times, separated by 1 low cycle each. done=1 one cycle after the final gap. short=0, remain=0, q_cnt=5.
- Defaults, amount=40 → pulse order relq, reld, reln. busy spans the job and done fires once. With CHANGE_STATS_EN, total_out=40.
- INIT_Q=1, INIT_D=1, INIT_N=1, amount=60 → relq, reld, reln, then done. short=1, remain=20, low_coin=1. Then refill in IDLE → counts become 1/1/1.
- amount=0 → no rel* pulses, done high in the 2nd cycle after start. amount=7 → one reln, remain=2, short=0.
- amount=100 with a second start (amount=25) pulsed while busy → exactly 4 relq pulses total. The second request is ignored.
- amount=75, reset asserted after the first relq → all outputs immediately at reset values, q_cnt=8, no further pulses.

Source files
------------

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
//
// Downstream stage of the vending controller. A one-cycle start strobe loads
// a change amount in cents, which is then paid out greedily as quarters,
// dimes and nickels. Each coin is one release pulse on relq/reld/reln. An
// on-board inventory is kept per denomination, and done/short status is
// reported back to the controller.
//
// Optional feature: define CHANGE_STATS_EN to build a 16-bit accumulator of
// cents dispensed on total_out. Without it, total_out is tied to zero.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   start      one-cycle request to dispense 'amount'
//   amount     change owed in cents, sampled with start
//   refill     reload inventory to INIT_* (honoured only when idle)
//   busy       dispensing in progress
//   done       one-cycle completion pulse
//   short      last job ended with 5 or more cents unpaid, held until next start
//   remain     cents still owed (residue after done)
//   relq/reld/reln  one-cycle release pulses for quarter/dime/nickel
//   q_cnt/d_cnt/n_cnt  current inventory
//   low_coin   any inventory counter is zero (combinational)
//   total_out  cumulative cents dispensed (zero unless CHANGE_STATS_EN)
// ---------------------------------------------------------------------------
module change_dispenser #(
    parameter int AMT_W  = 8,
    parameter int INV_W  = 6,
    parameter int INIT_Q = 8,
    parameter int INIT_D = 8,
    parameter int INIT_N = 8,
    parameter int GAP    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             refill,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remain,
    output logic             relq,
    output logic             reld,
    output logic             reln,
    output logic [INV_W-1:0] q_cnt,
    output logic [INV_W-1:0] d_cnt,
    output logic [INV_W-1:0] n_cnt,
    output logic             low_coin,
    output logic [15:0]      total_out
);

    // The gap counter only has to reach GAP-1; keep it at least one bit wide
    // so a zero-gap build still elaborates cleanly.
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0]    GAP_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [AMT_W-1:0] V25      = AMT_W'(25);
    localparam logic [AMT_W-1:0] V10      = AMT_W'(10);
    localparam logic [AMT_W-1:0] V5       = AMT_W'(5);
    localparam logic [INV_W-1:0] ONE      = INV_W'(1);
    localparam logic [INV_W-1:0] RST_Q    = INV_W'(INIT_Q);
    localparam logic [INV_W-1:0] RST_D    = INV_W'(INIT_D);
    localparam logic [INV_W-1:0] RST_N    = INV_W'(INIT_N);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISP,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t           state, state_next;
    logic [AMT_W-1:0] remain_next;
    logic [INV_W-1:0] q_next, d_next, n_next;
    logic             busy_next, done_next, short_next;
    logic             relq_next, reld_next, reln_next;
    logic [GW-1:0]    gap_cnt, gap_next;

    // Everything the controller sees is registered in this one block. The
    // reset branch is the abort path: any release pulse in flight drops at
    // once and the inventory returns to its loaded values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            remain  <= '0;
            q_cnt   <= RST_Q;
            d_cnt   <= RST_D;
            n_cnt   <= RST_N;
            busy    <= 1'b0;
            done    <= 1'b0;
            short   <= 1'b0;
            relq    <= 1'b0;
            reld    <= 1'b0;
            reln    <= 1'b0;
            gap_cnt <= '0;
        end else begin
            state   <= state_next;
            remain  <= remain_next;
            q_cnt   <= q_next;
            d_cnt   <= d_next;
            n_cnt   <= n_next;
            busy    <= busy_next;
            done    <= done_next;
            short   <= short_next;
            relq    <= relq_next;
            reld    <= reld_next;
            reln    <= reln_next;
            gap_cnt <= gap_next;
        end
    end

    // Next-state and next-output decisions. Release pulses and done default
    // low so they last exactly one cycle. In DISP the coin choice is a
    // strict priority chain, and each subtraction sits behind its own
    // compare, so neither remain nor a counter can wrap below zero.
    always_comb begin
        state_next  = state;
        remain_next = remain;
        q_next      = q_cnt;
        d_next      = d_cnt;
        n_next      = n_cnt;
        busy_next   = busy;
        done_next   = 1'b0;
        short_next  = short;
        relq_next   = 1'b0;
        reld_next   = 1'b0;
        reln_next   = 1'b0;
        gap_next    = gap_cnt;

        case (state)
            ST_IDLE: begin
                // Refill is applied first, so a job starting on the same
                // edge pays out from the reloaded inventory.
                if (refill) begin
                    q_next = RST_Q;
                    d_next = RST_D;
                    n_next = RST_N;
                end
                if (start) begin
                    remain_next = amount;
                    short_next  = 1'b0;
                    busy_next   = 1'b1;
                    state_next  = ST_DISP;
                end
            end
            ST_DISP: begin
                if (remain >= V25 && q_cnt != '0) begin
                    relq_next   = 1'b1;
                    remain_next = remain - V25;
                    q_next      = q_cnt - ONE;
                end else if (remain >= V10 && d_cnt != '0) begin
                    reld_next   = 1'b1;
                    remain_next = remain - V10;
                    d_next      = d_cnt - ONE;
                end else if (remain >= V5 && n_cnt != '0) begin
                    reln_next   = 1'b1;
                    remain_next = remain - V5;
                    n_next      = n_cnt - ONE;
                end else begin
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    short_next = (remain >= V5);
                    state_next = ST_DONE;
                end
                if ((relq_next || reld_next || reln_next) && (GAP > 0)) begin
                    state_next = ST_GAP;
                    gap_next   = '0;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = ST_DISP;
                end else begin
                    gap_next = gap_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign low_coin = (q_cnt == '0) || (d_cnt == '0) || (n_cnt == '0);

`ifdef CHANGE_STATS_EN
    logic [15:0] total_q;
    logic [4:0]  coin_val;

    // Value of the coin being released on this edge, taken from the same
    // decision that raises the pulse.
    assign coin_val = relq_next ? 5'd25 :
                      reld_next ? 5'd10 :
                      reln_next ? 5'd5  : 5'd0;

    // Running total of cents paid out. It wraps naturally at 16 bits, and
    // only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_q <= '0;
        end else begin
            total_q <= total_q + {11'd0, coin_val};
        end
    end

    assign total_out = total_q;
`else
    assign total_out = 16'd0;
`endif

endmodule
